// File: rtl/inert_spi_resp.sv
// Purpose: SPI mode-0 register responder for an inertial sensor (16-bit frames, 8-bit regs, sample snapshot + data-ready INT).
// Latency: SPI inputs see 2 sync flops + 1 edge-detect flop; writes/clears commit on the clk the synchronized SS_n rise is seen.
// Backpressure: none; smpl_vld is dropped (snapshot held) while INT is high.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   SS_n, SCLK, MOSI    SPI slave inputs (asynchronous to clk)
//   MISO                SPI data out, 0 outside the data byte of a read
//   INT                 data-ready interrupt, active-high
//   roll_in, yaw_in, ay_in, az_in, smpl_vld   sensor sample words and their one-clk valid strobe
// Optional: define INERT_SPI_RESP_STATUS_EN to map {6'b0, ovr, INT} at address 0x1E.
module inert_spi_resp #(
    parameter logic [7:0] WHO_AM_I = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] roll_in,
    input  logic [15:0] yaw_in,
    input  logic [15:0] ay_in,
    input  logic [15:0] az_in,
    input  logic        smpl_vld
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    typedef struct packed {
        logic [15:0] roll;
        logic [15:0] yaw;
        logic [15:0] ay;
        logic [15:0] az;
    } snap_t;

    state_t      state, state_nxt;
    logic        ss_s1, ss_s2, ss_s3;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        mosi_s1, mosi_s2;
    logic [1:0]  settle;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_in;
    logic [7:0]  shift_out;
    logic        rd_active;
    logic [7:0]  int_ctrl, ctrl1, ctrl2, ctrl5;
    snap_t       snap;
    logic        int_q;
    logic [7:0]  rd_byte;
    logic [6:0]  cmd_addr;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic        shift_en, rd_load, commit, wr_cmd, rd_commit, clr_int, snap_load;

    // Synchronizers. The settle counter blocks SS_n fall detection until the
    // whole SS_n chain holds real input samples, so a reset released while
    // SS_n is already low cannot fake the start of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            settle  <= 2'd0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ss_fall   = (settle == 2'd3) & ss_s3 & ~ss_s2;
    assign ss_rise   = ~ss_s3 & ss_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: if (ss_fall) state_nxt = CMD;
            CMD: begin
                shift_en = sclk_rise;
                if (sclk_rise && bit_cnt == 5'd7)
                    state_nxt = DATA;
            end
            DATA: begin
                shift_en = sclk_rise;
                if (sclk_rise && bit_cnt == 5'd15)
                    state_nxt = DONE;
            end
            DONE: commit = ss_rise;   // further SCLK edges are ignored here
            default: state_nxt = IDLE;
        endcase
        if (ss_rise)
            state_nxt = IDLE;
    end

    // Command byte as it completes on rising edge 8: shift_in still holds the
    // first seven bits, the eighth is the current synchronized MOSI.
    assign cmd_addr  = {shift_in[5:0], mosi_s2};
    assign rd_load   = shift_en && (state == CMD) && (bit_cnt == 5'd7) && shift_in[6];

    assign wr_cmd    = commit && !shift_in[15];
    assign rd_commit = commit &&  shift_in[15];
    assign clr_int   = rd_commit && (shift_in[14:8] == 7'h2D);
    assign snap_load = smpl_vld && !int_q && !clr_int;

    always_comb begin
        rd_byte = 8'h00;
        case (cmd_addr)
            7'h0D: rd_byte = int_ctrl;
            7'h0F: rd_byte = WHO_AM_I;
            7'h10: rd_byte = ctrl1;
            7'h11: rd_byte = ctrl2;
            7'h14: rd_byte = ctrl5;
`ifdef INERT_SPI_RESP_STATUS_EN
            7'h1E: rd_byte = {6'b0, ovr, int_q};
`endif
            7'h24: rd_byte = snap.roll[7:0];
            7'h25: rd_byte = snap.roll[15:8];
            7'h26: rd_byte = snap.yaw[7:0];
            7'h27: rd_byte = snap.yaw[15:8];
            7'h2A: rd_byte = snap.ay[7:0];
            7'h2B: rd_byte = snap.ay[15:8];
            7'h2C: rd_byte = snap.az[7:0];
            7'h2D: rd_byte = snap.az[15:8];
            default: rd_byte = 8'h00;
        endcase
    end

    // Frame datapath. The fall right after rising edge 8 must not shift:
    // the freshly loaded MSB has to survive until rising edge 9.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 5'd0;
            shift_in  <= 16'h0000;
            shift_out <= 8'h00;
            rd_active <= 1'b0;
        end else begin
            if (ss_fall)
                bit_cnt <= 5'd0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 5'd1;

            if (ss_fall)
                shift_in <= 16'h0000;
            else if (shift_en)
                shift_in <= {shift_in[14:0], mosi_s2};

            if (ss_fall || ss_rise)
                rd_active <= 1'b0;
            else if (rd_load)
                rd_active <= 1'b1;

            if (ss_fall)
                shift_out <= 8'h00;
            else if (rd_load)
                shift_out <= rd_byte;
            else if (sclk_fall && state == DATA && bit_cnt >= 5'd9)
                shift_out <= {shift_out[6:0], 1'b0};
        end
    end

    assign MISO = rd_active & shift_out[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_ctrl <= 8'h00;
            ctrl1    <= 8'h00;
            ctrl2    <= 8'h00;
            ctrl5    <= 8'h00;
            snap     <= '0;
            int_q    <= 1'b0;
        end else begin
            if (wr_cmd) begin
                case (shift_in[14:8])
                    7'h0D: int_ctrl <= shift_in[7:0];
                    7'h10: ctrl1    <= shift_in[7:0];
                    7'h11: ctrl2    <= shift_in[7:0];
                    7'h14: ctrl5    <= shift_in[7:0];
                    default: ;
                endcase
            end
            if (snap_load)
                snap <= '{roll: roll_in, yaw: yaw_in, ay: ay_in, az: az_in};
            // Clears (read of 0x2D, or INT_CTRL[1] written to 0) beat a set.
            if (clr_int || (wr_cmd && shift_in[14:8] == 7'h0D && !shift_in[1]))
                int_q <= 1'b0;
            else if (snap_load && int_ctrl[1])
                int_q <= 1'b1;
        end
    end

    assign INT = int_q;

`ifdef INERT_SPI_RESP_STATUS_EN
    logic ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr <= 1'b0;
        else if (smpl_vld && int_q)
            ovr <= 1'b1;
        else if (rd_commit && shift_in[14:8] == 7'h1E)
            ovr <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_inert_spi_resp.sv
// Purpose: self-checking bench for inert_spi_resp (directed vector table, hand sequences, random frames vs. a register-map model).
// Latency: SPI half-period of 6 clk; MISO is sampled just before each SCLK rise, as a mode-0 master would.
// Backpressure: none; all stimulus is paced by fixed clk counts and a watchdog bounds the run.
module tb_inert_spi_resp;

    localparam int H = 6;

`ifdef INERT_SPI_RESP_STATUS_EN
    localparam logic [7:0] ST_FIRST  = 8'h03;
    localparam logic [7:0] ST_SECOND = 8'h01;
`else
    localparam logic [7:0] ST_FIRST  = 8'h00;
    localparam logic [7:0] ST_SECOND = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI, smpl_vld;
    logic        MISO, INT;
    logic [15:0] roll_in, yaw_in, ay_in, az_in;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inert_spi_resp #(.WHO_AM_I(8'h6A)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .INT(INT),
        .roll_in(roll_in), .yaw_in(yaw_in), .ay_in(ay_in), .az_in(az_in),
        .smpl_vld(smpl_vld)
    );

    typedef struct {
        logic [15:0] word;
        int          nrise;
        bit          chk;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    // Register-map model used by the random phase.
    logic [7:0]  m_int_ctrl, m_ctrl1, m_ctrl2, m_ctrl5;
    logic [15:0] m_roll, m_yaw, m_ay, m_az;
    bit          m_int, m_ovr;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_vec(input logic [15:0] w, input int n, input bit c, input logic [7:0] e, input string nm);
        vec_t v;
        v.word = w; v.nrise = n; v.chk = c; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic sclk_bit(input logic b, output logic m);
        MOSI = b;
        wait_clk(H);
        m = MISO;
        SCLK = 1'b1;
        wait_clk(H);
        SCLK = 1'b0;
    endtask

    // Runs one frame; rd collects MISO before rises 9..16, quiet is 1 when
    // MISO stayed 0 before rises 1..8.
    task automatic spi_frame(input logic [15:0] w, input int nrise, input bit raise,
                             output logic [7:0] rd, output bit quiet);
        logic m, b;
        rd = 8'h00;
        quiet = 1'b1;
        SS_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nrise; i++) begin
            if (i < 16) b = w[15 - i];
            else        b = 1'b0;
            sclk_bit(b, m);
            if (i < 8) begin
                if (m !== 1'b0) quiet = 1'b0;
            end else if (i < 16) begin
                rd = {rd[6:0], m};
            end
        end
        if (raise) begin
            wait_clk(H);
            SS_n = 1'b1;
            wait_clk(H);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] w, input logic [7:0] exp);
        logic [7:0] rd;
        bit q;
        spi_frame(w, 16, 1'b1, rd, q);
        check(nm, {8'h00, rd}, {8'h00, exp});
        check({nm, "_cmd_quiet"}, {15'h0, q}, 16'h1);
    endtask

    task automatic pulse_smpl(input logic [15:0] r, input logic [15:0] y, input logic [15:0] a, input logic [15:0] z);
        roll_in = r; yaw_in = y; ay_in = a; az_in = z;
        smpl_vld = 1'b1;
        wait_clk(1);
        smpl_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
    endtask

    function automatic logic [7:0] m_read(input logic [6:0] a);
        case (a)
            7'h0D: return m_int_ctrl;
            7'h0F: return 8'h6A;
            7'h10: return m_ctrl1;
            7'h11: return m_ctrl2;
            7'h14: return m_ctrl5;
`ifdef INERT_SPI_RESP_STATUS_EN
            7'h1E: return {6'b0, m_ovr, m_int};
`endif
            7'h24: return m_roll[7:0];
            7'h25: return m_roll[15:8];
            7'h26: return m_yaw[7:0];
            7'h27: return m_yaw[15:8];
            7'h2A: return m_ay[7:0];
            7'h2B: return m_ay[15:8];
            7'h2C: return m_az[7:0];
            7'h2D: return m_az[15:8];
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       m;
        bit         q;
        logic [15:0] w;
        logic [6:0] pool [20];
        pool = '{7'h0D, 7'h0D, 7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h1E, 7'h24, 7'h25,
                 7'h26, 7'h27, 7'h2A, 7'h2B, 7'h2C, 7'h2D, 7'h2D, 7'h2D, 7'h12, 7'h7F};

        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; smpl_vld = 1'b0;
        roll_in = '0; yaw_in = '0; ay_in = '0; az_in = '0;
        wait_clk(3);
        check("reset_miso", {15'h0, MISO}, 16'h0);
        check("reset_int",  {15'h0, INT},  16'h0);
        rst = 1'b0;
        wait_clk(4);
        check("post_reset_int", {15'h0, INT}, 16'h0);

        // Directed frame table.
        add_vec(16'h0D02, 16, 1, 8'h00, "wr_int_ctrl");
        add_vec(16'h8DFF, 16, 1, 8'h02, "rd_int_ctrl");
        add_vec(16'h8FFF, 16, 1, 8'h6A, "rd_who_am_i");
        add_vec(16'h1055, 10, 0, 8'h00, "abort_wr_ctrl1");
        add_vec(16'h90FF, 16, 1, 8'h00, "rd_ctrl1_after_abort");
        add_vec(16'h1433, 16, 1, 8'h00, "wr_ctrl5");
        add_vec(16'h9433, 16, 1, 8'h33, "rd_ctrl5");
        add_vec(16'h1299, 16, 1, 8'h00, "wr_unmapped");
        add_vec(16'h92FF, 16, 1, 8'h00, "rd_unmapped");
        add_vec(16'h0F12, 16, 1, 8'h00, "wr_read_only");
        add_vec(16'h8FFF, 20, 1, 8'h6A, "rd_who_am_i_extra_edges");
        add_vec(16'h10A5, 20, 1, 8'h00, "wr_ctrl1_extra_edges");
        add_vec(16'h90FF, 16, 1, 8'hA5, "rd_ctrl1");
        add_vec(16'h1166, 16, 1, 8'h00, "wr_ctrl2");
        add_vec(16'h9100, 16, 1, 8'h66, "rd_ctrl2");

        foreach (tbl[i]) begin
            spi_frame(tbl[i].word, tbl[i].nrise, 1'b1, rd, q);
            check({tbl[i].name, "_cmd_quiet"}, {15'h0, q}, 16'h1);
            if (tbl[i].chk)
                check(tbl[i].name, {8'h00, rd}, {8'h00, tbl[i].exp});
        end

        // Sample snapshot and INT handshake (INT_CTRL = 0x02 from the table).
        check("int_before_sample", {15'h0, INT}, 16'h0);
        pulse_smpl(16'h1234, 16'h5678, 16'h9ABC, 16'hBEEF);
        check("int_after_sample", {15'h0, INT}, 16'h1);
        rd_chk("rd_roll_lo", 16'hA4FF, 8'h34);
        rd_chk("rd_roll_hi", 16'hA5FF, 8'h12);
        rd_chk("rd_yaw_lo",  16'hA6FF, 8'h78);
        rd_chk("rd_ay_hi",   16'hABFF, 8'h9A);
        rd_chk("rd_az_lo",   16'hACFF, 8'hEF);
        check("int_after_az_lo", {15'h0, INT}, 16'h1);
        rd_chk("rd_az_hi",   16'hADFF, 8'hBE);
        check("int_after_az_hi", {15'h0, INT}, 16'h0);

        // Clear and sample arriving on the same clk: the sample is dropped.
        pulse_smpl(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("int_second_sample", {15'h0, INT}, 16'h1);
        spi_frame(16'hADFF, 16, 1'b0, rd, q);
        check("rd_az_hi_b", {8'h00, rd}, 16'h0044);
        wait_clk(H);
        SS_n = 1'b1;
        wait_clk(2);
        pulse_smpl(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        wait_clk(H);
        check("int_clear_wins", {15'h0, INT}, 16'h0);
        rd_chk("snap_held_after_clear", 16'hA4FF, 8'h11);
        spi_frame(16'h9EFF, 16, 1'b1, rd, q);

        // Overrun: second sample dropped while INT is high.
        pulse_smpl(16'hC0C1, 16'h0000, 16'h0000, 16'hC2C3);
        wait_clk(2);
        pulse_smpl(16'hD0D1, 16'h0000, 16'h0000, 16'hD2D3);
        wait_clk(2);
        rd_chk("snap_holds_first", 16'hA4FF, 8'hC1);
        rd_chk("status_first",     16'h9EFF, ST_FIRST);
        rd_chk("status_second",    16'h9EFF, ST_SECOND);
        rd_chk("rd_az_hi_c",       16'hADFF, 8'hC2);
        check("int_after_ovr_clear", {15'h0, INT}, 16'h0);

        // Reset in the middle of a write frame.
        pulse_smpl(16'hAAAA, 16'h0000, 16'h0000, 16'h0000);
        check("int_before_midreset", {15'h0, INT}, 16'h1);
        w = 16'h1150;
        SS_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 12; i++) sclk_bit(w[15 - i], m);
        rst = 1'b1;
        wait_clk(2);
        check("midreset_miso", {15'h0, MISO}, 16'h0);
        check("midreset_int",  {15'h0, INT},  16'h0);
        rst = 1'b0;
        wait_clk(2);
        for (int i = 12; i < 16; i++) sclk_bit(w[15 - i], m);
        wait_clk(H);
        SS_n = 1'b1;
        wait_clk(H);
        rd_chk("ctrl2_after_midreset",    16'h91FF, 8'h00);
        rd_chk("int_ctrl_after_midreset", 16'h8DFF, 8'h00);
        rd_chk("snap_after_midreset",     16'hA5FF, 8'h00);
        spi_frame(16'h1177, 16, 1'b1, rd, q);
        rd_chk("ctrl2_after_recovery",    16'h91FF, 8'h77);
        check("int_after_midreset", {15'h0, INT}, 16'h0);

        // Random frames and samples against the register-map model.
        do_reset();
        m_int_ctrl = 0; m_ctrl1 = 0; m_ctrl2 = 0; m_ctrl5 = 0;
        m_roll = 0; m_yaw = 0; m_ay = 0; m_az = 0; m_int = 0; m_ovr = 0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [15:0] r, y, a, z;
                r = 16'($urandom); y = 16'($urandom); a = 16'($urandom); z = 16'($urandom);
                pulse_smpl(r, y, a, z);
                if (!m_int) begin
                    m_roll = r; m_yaw = y; m_ay = a; m_az = z;
                    if (m_int_ctrl[1]) m_int = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                wait_clk(2);
                check("rnd_int_after_sample", {15'h0, INT}, {15'h0, m_int});
            end else begin
                logic       is_rd;
                logic [6:0] addr;
                logic [7:0] data, exp;
                int         sel, nr;
                is_rd = 1'($urandom_range(0, 1));
                addr  = pool[$urandom_range(0, 19)];
                data  = 8'($urandom);
                sel   = $urandom_range(0, 9);
                if (sel == 0)      nr = $urandom_range(1, 15);
                else if (sel == 1) nr = $urandom_range(17, 20);
                else               nr = 16;
                exp = is_rd ? m_read(addr) : 8'h00;
                spi_frame({is_rd, addr, data}, nr, 1'b1, rd, q);
                check("rnd_cmd_quiet", {15'h0, q}, 16'h1);
                if (nr >= 16) begin
                    check("rnd_miso_byte", {8'h00, rd}, {8'h00, exp});
                    if (!is_rd) begin
                        case (addr)
                            7'h0D: begin m_int_ctrl = data; if (!data[1]) m_int = 1'b0; end
                            7'h10: m_ctrl1 = data;
                            7'h11: m_ctrl2 = data;
                            7'h14: m_ctrl5 = data;
                            default: ;
                        endcase
                    end else if (addr == 7'h2D) begin
                        m_int = 1'b0;
                    end else if (addr == 7'h1E) begin
                        m_ovr = 1'b0;
                    end
                end
                check("rnd_int_after_frame", {15'h0, INT}, {15'h0, m_int});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inert_spi_resp.md
INERT_SPI_RESP -- requirements
Module: inert_spi_resp

Interface
REQ-001 Parameter WHO_AM_I, default 8'h6A, value returned for a read of address 0x0F.
REQ-002 clk  input  1  single clock; every flop uses it.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 SS_n  input  1  SPI select, active-low, asynchronous to clk.
REQ-005 SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-006 MOSI  input  1  SPI data from the master.
REQ-007 MISO  output  1  SPI data to the master.
REQ-008 INT  output  1  data-ready interrupt, active-high.
REQ-009 roll_in, yaw_in, ay_in, az_in  input  16 each  sensor sample words.
REQ-010 smpl_vld  input  1  one-clk pulse; the sample inputs are valid in that cycle.

Function
REQ-011 SS_n, SCLK and MOSI SHALL pass through a 2-flop synchronizer; an SCLK rise or fall SHALL be detected on the third flop; the master guarantees an SCLK half-period of at least 4 clk.
REQ-012 Frame format: 16 bits, MSB first; MOSI sampled on the synchronized SCLK rise; MISO changes on the SCLK fall.
REQ-013 First byte is the command: bit7=1 is a read, bit7=0 is a write; bits[6:0] are the address. Second byte is the write data, or don't-care for a read.
REQ-014 State machine IDLE->CMD on the SS_n fall. CMD->DATA after rising edge 8. DATA->DONE after rising edge 16. Any state->IDLE on the SS_n rise.
REQ-015 MISO SHALL be 0 in IDLE and CMD. For a read, the selected byte SHALL be loaded at rising edge 8, and its MSB SHALL be on MISO before rising edge 9. For a write, MISO SHALL be 0.
REQ-016 Writes SHALL commit on the clk after the synchronized SS_n rise, only if exactly 16 rising edges were counted.
REQ-017 Writable registers (reset 0x00, readable back): 0x0D INT_CTRL, 0x10 CTRL1, 0x11 CTRL2, 0x14 CTRL5. Writes to any other address SHALL be ignored.
REQ-018 Read-only registers:
- 0x0F = WHO_AM_I
- 0x24/0x25 = roll low/high
- 0x26/0x27 = yaw low/high
- 0x2A/0x2B = AY low/high
- 0x2C/0x2D = AZ low/high, all taken from the snapshot
- every unmapped address reads 0x00.
REQ-019 Snapshot (4x16 bits) SHALL load on smpl_vld when INT is 0. While INT is 1, a new sample SHALL be dropped and the snapshot held.
REQ-020 INT SHALL rise on the clk after a snapshot load if INT_CTRL[1]=1. A snapshot load with INT_CTRL[1]=0 SHALL NOT assert INT.
REQ-021 INT SHALL clear when a complete 16-bit read of 0x2D commits (same timing as REQ-016).
REQ-022 A clear and a smpl_vld in the same clk: the clear wins and the sample is dropped.
REQ-023 A frame aborted early (SS_n rises before 16 edges) SHALL write nothing and SHALL NOT clear INT or status. SCLK edges beyond 16 SHALL be ignored.
REQ-024 Clearing INT_CTRL[1] SHALL deassert INT on the commit clk.

Reset
REQ-025 rst asserted SHALL force, asynchronously:
- state = IDLE
- bit counter = 0, shift registers = 0
- MISO = 0, INT = 0
- all writable registers = 0x00
- snapshot = 0
- synchronizer flops: SS_n flops = 1, SCLK and MOSI flops = 0.
REQ-026 rst mid-frame SHALL abandon the frame. The block SHALL wait for the next SS_n fall and SHALL NOT treat the ongoing frame's remaining edges as a new frame.

Configuration
REQ-027 Macro INERT_SPI_RESP_STATUS_EN. When defined:
- address 0x1E reads {6'b0, ovr, INT}
- ovr is set by a sample dropped per REQ-019
- ovr is cleared on a committed read of 0x1E; a set in the same clk wins.
REQ-028 When INERT_SPI_RESP_STATUS_EN is undefined, 0x1E SHALL read 0x00 and no ovr logic SHALL exist.

Verification
REQ-029 Write frame 0x0D02, then read frame 0x8DFF -> INT_CTRL = 0x02; MISO byte = 0x02.
REQ-030 Read frame 0x8FFF -> MISO byte = 0x6A; MISO = 0 for the first 8 bits.
REQ-031 INT_CTRL = 0x02, smpl_vld with roll_in = 0x1234 and az_in = 0xBEEF:
- INT = 1 one clk later
- read 0xA4 -> 0x34; read 0xA5 -> 0x12
- read 0xAC -> 0xEF; INT still 1
- read 0xAD -> 0xBE; INT = 0 after SS_n rises.
REQ-032 Frame 0x1055 aborted after 10 SCLK rises -> CTRL1 stays 0x00; a following full read of 0x90FF returns 0x00.
REQ-033 INT_CTRL = 0x02, two smpl_vld pulses with no reads:
- snapshot holds the first sample
- read 0x9E -> 0x03 with INERT_SPI_RESP_STATUS_EN defined, 0x00 without
- a second read of 0x9E -> 0x01 with the macro.
REQ-034 rst pulsed after 12 SCLK rises of write 0x1150 -> CTRL2 = 0x00, INT = 0, MISO = 0; the next full frame decodes correctly.
